// File: rtl/nonsynth_ethernet_sender_mq.sv
// nonsynth_ethernet_sender_mq: multi-slot queued Ethernet TX frame source onto AXI-Stream; define ETH_SENDER_PAD_EN to pad short frames to min_frame_p
module nonsynth_ethernet_sender_mq #(
  parameter int buf_size_p   = 2048,
  parameter int send_width_p = 8,
  parameter int num_slots_p  = 4,
  parameter int gap_delay_p  = 24,
  parameter int min_frame_p  = 60,
  localparam int slot_w = $clog2(num_slots_p),
  localparam int addr_w = (buf_size_p / send_width_p) > 1 ? $clog2(buf_size_p / send_width_p) : 1,
  localparam int size_w = $clog2(buf_size_p) + 1
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      wr_v_i,
  input  logic [slot_w-1:0]         wr_slot_i,
  input  logic [addr_w-1:0]         wr_addr_i,
  input  logic [8*send_width_p-1:0] wr_data_i,
  output logic [num_slots_p-1:0]    slot_free_o,
  input  logic                      commit_v_i,
  output logic                      commit_ready_o,
  input  logic [slot_w-1:0]         commit_slot_i,
  input  logic [size_w-1:0]         commit_size_i,
  output logic                      commit_err_o,
  output logic [8*send_width_p-1:0] tx_axis_tdata_o,
  output logic [send_width_p-1:0]   tx_axis_tkeep_o,
  output logic                      tx_axis_tvalid_o,
  output logic                      tx_axis_tlast_o,
  input  logic                      tx_axis_tready_i,
  output logic                      tx_axis_tuser_o,
  output logic                      sent_v_o,
  output logic [slot_w-1:0]         sent_slot_o
);
  localparam int lane_w = $clog2(send_width_p);
  localparam int gap_w = $clog2(gap_delay_p) + 1;
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  if (gap_delay_p < 1) begin : g_gap_check
    $error("gap_delay_p must be at least 1");
  end
  state_t state;
  logic [8*send_width_p-1:0] mem [num_slots_p << addr_w];
  logic [slot_w-1:0] q_slot [num_slots_p];
  logic [size_w-1:0] q_size [num_slots_p];
  logic [slot_w-1:0] wp, rp, slot_r, sent_slot;
  logic [slot_w:0] count;
  logic [size_w-1:0] size_r, head_size, eff_size;
  logic [addr_w-1:0] ptr, end_r, head_end, nxt;
  logic [gap_w-1:0] gap_cnt;
  logic [num_slots_p-1:0] free, clr, set;
  logic fire, bad, push, pop, adv, tvalid, tlast, sent_v, err;
  logic [send_width_p-1:0] tkeep;
  logic [8*send_width_p-1:0] tdata;
  function automatic logic [send_width_p-1:0] keep_f(input logic last, input logic [size_w-1:0] size);
    int rem;
    rem = int'(size) % send_width_p;
    return (last && rem != 0) ? send_width_p'((64'd1 << rem) - 64'd1) : '1;
  endfunction
  assign fire = commit_v_i && commit_ready_o;
  assign bad = commit_size_i == '0 || commit_size_i > size_w'(buf_size_p) || !free[commit_slot_i];
  assign push = fire && !bad;
  assign pop = state == IDLE && count != '0;
  assign adv = state == SEND && tx_axis_tready_i;
  assign head_size = q_size[rp];
  assign head_end = addr_w'((eff_size - size_w'(1)) >> lane_w);
  assign nxt = ptr + 1'b1;
  assign clr = push ? num_slots_p'(1) << commit_slot_i : '0;
  assign set = (adv && tlast) ? num_slots_p'(1) << slot_r : '0;
`ifdef ETH_SENDER_PAD_EN
  logic [size_w-1:0] raw_r;
  assign eff_size = head_size < size_w'(min_frame_p) ? size_w'(min_frame_p) : head_size;
  // Remember the committed length so the padded tail reads as zeros
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) raw_r <= '0;
    else if (pop) raw_r <= head_size;
  end
  // Zero bytes past the committed length so padding never leaks stale buffer contents
  always_comb begin
    tdata = mem[{slot_r, ptr}];
    for (int j = 0; j < send_width_p; j++)
      if (int'(ptr) * send_width_p + j >= int'(raw_r)) tdata[8*j +: 8] = 8'h00;
  end
`else
  assign eff_size = head_size;
  assign tdata = mem[{slot_r, ptr}];
`endif
  // Frame buffers and commit FIFO payload are plain storage and are never reset
  always_ff @(posedge clk_i) begin
    if (wr_v_i && free[wr_slot_i]) mem[{wr_slot_i, wr_addr_i}] <= wr_data_i;
    if (push) begin
      q_slot[wp] <= commit_slot_i;
      q_size[wp] <= commit_size_i;
    end
  end
  // Commit FIFO pointers, slot ownership and the IDLE/SEND/GAP drain FSM with registered stream outputs
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      count <= '0;
      free <= '1;
      slot_r <= '0;
      size_r <= '0;
      end_r <= '0;
      ptr <= '0;
      gap_cnt <= '0;
      tvalid <= 1'b0;
      tlast <= 1'b0;
      tkeep <= '0;
      sent_v <= 1'b0;
      sent_slot <= '0;
      err <= 1'b0;
    end else begin
      err <= fire && bad;
      sent_v <= 1'b0;
      free <= (free & ~clr) | set;
      count <= count + (slot_w+1)'(push) - (slot_w+1)'(pop);
      if (push) wp <= wp + 1'b1;
      case (state)
        IDLE: if (pop) begin
          rp <= rp + 1'b1;
          slot_r <= q_slot[rp];
          size_r <= eff_size;
          end_r <= head_end;
          ptr <= '0;
          tvalid <= 1'b1;
          tlast <= head_end == '0;
          tkeep <= keep_f(head_end == '0, eff_size);
          state <= SEND;
        end
        SEND: if (adv) begin
          if (tlast) begin
            tvalid <= 1'b0;
            tlast <= 1'b0;
            tkeep <= '0;
            sent_v <= 1'b1;
            sent_slot <= slot_r;
            gap_cnt <= gap_w'(gap_delay_p - 1);
            state <= GAP;
          end else begin
            ptr <= nxt;
            tlast <= nxt == end_r;
            tkeep <= keep_f(nxt == end_r, size_r);
          end
        end
        GAP: if (gap_cnt == '0) state <= IDLE;
             else gap_cnt <= gap_cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
  assign slot_free_o = free;
  assign commit_ready_o = count != (slot_w+1)'(num_slots_p);
  assign commit_err_o = err;
  assign tx_axis_tdata_o = tdata;
  assign tx_axis_tkeep_o = tkeep;
  assign tx_axis_tvalid_o = tvalid;
  assign tx_axis_tlast_o = tlast;
  assign tx_axis_tuser_o = 1'b0;
  assign sent_v_o = sent_v;
  assign sent_slot_o = sent_slot;
endmodule

// File: tb/tb_nonsynth_ethernet_sender_mq.sv
// tb_nonsynth_ethernet_sender_mq: frame-level model bench for the queued Ethernet sender
module tb_nonsynth_ethernet_sender_mq;
  localparam int W = 8, S = 4, BUF = 2048, GAP = 24, MINF = 60;
`ifdef ETH_SENDER_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif
  logic clk = 1'b0, reset_n;
  logic wr_v = 1'b0;
  logic [1:0] wr_slot = '0;
  logic [7:0] wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic [3:0] slot_free;
  logic commit_v = 1'b0, commit_ready, commit_err;
  logic [1:0] commit_slot = '0;
  logic [11:0] commit_size = '0;
  logic [63:0] tdata;
  logic [7:0] tkeep;
  logic tvalid, tlast, tuser, sent_v;
  logic tready = 1'b1;
  logic [1:0] sent_slot;

  nonsynth_ethernet_sender_mq dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .wr_v_i(wr_v), .wr_slot_i(wr_slot), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .slot_free_o(slot_free),
    .commit_v_i(commit_v), .commit_ready_o(commit_ready), .commit_slot_i(commit_slot),
    .commit_size_i(commit_size), .commit_err_o(commit_err),
    .tx_axis_tdata_o(tdata), .tx_axis_tkeep_o(tkeep), .tx_axis_tvalid_o(tvalid),
    .tx_axis_tlast_o(tlast), .tx_axis_tready_i(tready), .tx_axis_tuser_o(tuser),
    .sent_v_o(sent_v), .sent_slot_o(sent_slot)
  );

  always #5 clk = ~clk;

  typedef struct {int slot; int size; int cyc;} frm_t;
  frm_t q[$], cq[$], f;
  logic [7:0] smem [S][BUF];
  bit busy [S];
  int cyc = 0, checks = 0, errors = 0, frames_done = 0;
  int bi = 0, prev_last = -1000, sent_due = -1, sent_exp = 0, n, eff, last_nb = 0;
  bit started = 1'b0, el;
  logic [7:0] ek, last_keep = '0;
  logic [63:0] ed;
  int sent_log[$], gap_log[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit slot_busy(input int s);
    bit b = busy[s];
    foreach (cq[i]) if (cq[i].slot == s) b = 1'b1;
    return b;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Model: frames leave in commit order; first beat at max(commit+2, prev tlast + gap + 2)
  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      cq.delete();
      foreach (busy[i]) busy[i] = 1'b0;
      bi = 0;
      started = 1'b0;
      prev_last = -1000;
      sent_due = -1;
      chk("rst_tvalid", tvalid, 0);
      chk("rst_tlast", tlast, 0);
      chk("rst_tkeep", tkeep, 0);
      chk("rst_sent", sent_v, 0);
      chk("rst_err", commit_err, 0);
      chk("rst_free", slot_free, 4'hF);
      chk("rst_ready", commit_ready, 1);
    end else begin
      while (cq.size() > 0) begin
        q.push_back(cq[0]);
        busy[cq[0].slot] = 1'b1;
        void'(cq.pop_front());
      end
      chk("slot_free", slot_free, {~busy[3], ~busy[2], ~busy[1], ~busy[0]});
      chk("tuser", tuser, 0);
      chk("sent_v", sent_v, cyc == sent_due);
      if (cyc == sent_due) begin
        chk("sent_slot", sent_slot, sent_exp);
        sent_log.push_back(int'(sent_slot));
      end
      if (q.size() > 0 && (started || cyc >= ((q[0].cyc + 2 > prev_last + GAP + 2) ? q[0].cyc + 2 : prev_last + GAP + 2))) begin
        f = q[0];
        eff = (PAD && f.size < MINF) ? MINF : f.size;
        if (!started) begin
          started = 1'b1;
          if (prev_last >= 0) gap_log.push_back(cyc - prev_last - 1);
        end
        n = eff - bi * W;
        if (n > W) n = W;
        ek = (n >= W) ? 8'hFF : 8'((1 << n) - 1);
        el = (bi + 1) * W >= eff;
        for (int j = 0; j < W; j++)
          ed[8*j +: 8] = (PAD && bi * W + j >= f.size) ? 8'h00 : smem[f.slot][bi * W + j];
        chk("tvalid", tvalid, 1);
        chk("tdata", tdata, ed);
        chk("tkeep", tkeep, ek);
        chk("tlast", tlast, el);
        if (tready) begin
          if (el) begin
            last_nb = bi + 1;
            last_keep = ek;
            prev_last = cyc;
            sent_due = cyc + 1;
            sent_exp = f.slot;
            busy[f.slot] = 1'b0;
            void'(q.pop_front());
            bi = 0;
            started = 1'b0;
            frames_done++;
          end else bi++;
        end
      end else chk("idle_tvalid", tvalid, 0);
    end
  end

  task automatic write_frame(input int s, input int size, input int seed);
    logic [7:0] v;
    for (int b = 0; b < (size + W - 1) / W; b++) begin
      @(posedge clk); #1;
      wr_v = 1'b1;
      wr_slot = 2'(s);
      wr_addr = 8'(b);
      for (int j = 0; j < W; j++) begin
        v = 8'(s * 16 + (b * W + j) * 3 + seed);
        wr_data[8*j +: 8] = v;
        if (!slot_busy(s)) smem[s][b * W + j] = v;
      end
    end
    @(posedge clk); #1;
    wr_v = 1'b0;
  endtask

  task automatic commit(input int s, input int size, input bit full);
    bit bad;
    int t;
    @(posedge clk); #1;
    t = cyc;
    bad = size == 0 || size > BUF || slot_busy(s);
    commit_v = 1'b1;
    commit_slot = 2'(s);
    commit_size = 12'(size);
    @(posedge clk); #1;
    commit_v = 1'b0;
    if (!full && !bad) cq.push_back('{s, size, t});
    @(negedge clk);
    chk("commit_err", commit_err, !full && bad);
  endtask

  task automatic wait_done(input int target);
    int k = 0;
    while (frames_done < target && k < 3000) begin
      @(posedge clk);
      k++;
    end
    checks++;
    if (frames_done < target) begin
      errors++;
      $display("FAIL wait_done: frames %0d required %0d", frames_done, target);
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int k, ns, ng, snap;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    write_frame(0, 64, 1);
    commit(0, 64, 0);
    wait_done(1);
    chk("t64_beats", last_nb, 8);
    chk("t64_keep", last_keep, 8'hFF);
    chk("t64_slot", sent_log.size() > 0 ? sent_log[sent_log.size() - 1] : -1, 0);
    write_frame(1, 13, 2);
    commit(1, 13, 0);
    wait_done(2);
    chk("t13_beats", last_nb, PAD ? 8 : 2);
    chk("t13_keep", last_keep, PAD ? 8'h0F : 8'h1F);
    write_frame(2, 8, 3);
    commit(2, 8, 0);
    wait_done(3);
    chk("t8_beats", last_nb, PAD ? 8 : 1);
    chk("t8_keep", last_keep, PAD ? 8'h0F : 8'hFF);
    write_frame(2, 17, 4);
    write_frame(0, 24, 5);
    write_frame(1, 9, 6);
    commit(2, 17, 0);
    commit(0, 24, 0);
    commit(1, 9, 0);
    wait_done(6);
    ns = sent_log.size();
    ng = gap_log.size();
    chk("order0", ns >= 3 ? sent_log[ns - 3] : -1, 2);
    chk("order1", ns >= 3 ? sent_log[ns - 2] : -1, 0);
    chk("order2", ns >= 3 ? sent_log[ns - 1] : -1, 1);
    chk("gap_a", ng >= 2 ? gap_log[ng - 2] : -1, 25);
    chk("gap_b", ng >= 2 ? gap_log[ng - 1] : -1, 25);
    write_frame(3, 24, 7);
    commit(3, 24, 0);
    k = 0;
    while (frames_done < 7 && k < 200) begin
      @(posedge clk); #1;
      tready = ~tready;
      k++;
    end
    tready = 1'b1;
    wait_done(7);
    chk("toggle_beats", last_nb, PAD ? 8 : 3);
    write_frame(0, 20, 8);
    commit(0, 20, 0);
    wait_done(8);
    chk("t20_beats", last_nb, PAD ? 8 : 3);
    chk("t20_keep", last_keep, 8'h0F);
    write_frame(1, 16, 9);
    write_frame(2, 16, 10);
    write_frame(3, 16, 11);
    write_frame(0, 16, 12);
    commit(0, 16, 0);
    wait_done(9);
    commit(1, 16, 0);
    commit(2, 16, 0);
    commit(3, 16, 0);
    commit(0, 16, 0);
    chk("fifo_full_ready", commit_ready, 0);
    chk("fifo_full_free", slot_free, 4'h0);
    commit(2, 8, 1);
    wait_done(13);
    commit(1, 0, 0);
    commit(1, 2049, 0);
    commit(1, 8, 0);
    commit(1, 8, 0);
    write_frame(1, 8, 99);
    wait_done(14);
    write_frame(2, 64, 13);
    commit(2, 64, 0);
    k = 0;
    while (!tvalid && k < 100) begin
      @(posedge clk);
      k++;
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b0;
    snap = frames_done;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("abandon_frames", frames_done, snap);
    chk("abandon_free", slot_free, 4'hF);
    write_frame(3, 13, 14);
    commit(3, 13, 0);
    wait_done(snap + 1);
    chk("recover_slot", sent_log.size() > 0 ? sent_log[sent_log.size() - 1] : -1, 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
